// File: rtl/fsk_tx_pkg.sv
// Shared definitions for the FSK transmit path: serializer FSM states and
// the default sync word/length that the receiver's sync detector also uses.
package fsk_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } tx_state_e;

    localparam int          DEF_SYNC_LEN  = 8;
    localparam logic [15:0] DEF_SYNC_WORD = 16'h00A5;

    // Select one bit of a sync word by run-time index (0..15)
    function automatic logic sync_bit(input logic [15:0] word, input int idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == idx) begin
                b = word[i];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fsk_frame_serializer_if.sv
// Sample handshake plus modulator-side outputs of the frame serializer.
// The master is the ADC capture side; the slave is the serializer.
interface fsk_frame_serializer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     ctrl_bit;
    logic                     ctrl_en;
    logic                     frame_start;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_level;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready,
        input  ctrl_bit,
        input  ctrl_en,
        input  frame_start,
        input  overflow,
        input  fifo_level
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready,
        output ctrl_bit,
        output ctrl_en,
        output frame_start,
        output overflow,
        output fifo_level
    );
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for ADC samples. The caller guarantees push only
// when not full and pop only when not empty; pointers wrap modulo DEPTH.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk_16,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointer and level registers are cleared by reset
    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage needs no reset; empty entries are never read
    always_ff @(posedge clk_16) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/fsk_frame_serializer.sv
// Framed parallel-to-serial stage feeding the FSK modulator. Buffers samples,
// prefixes each with the sync word and shifts one bit per clk_16 cycle.
module fsk_frame_serializer
    import fsk_tx_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          DEPTH     = 4,
    parameter int          SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          SKIP_ZERO = 1'b1
) (
    input  logic                  clk_16,
    input  logic                  reset,
    fsk_frame_serializer_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2((WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN) + 1;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ctrl_bit_q, ctrl_bit_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic             frame_start_q, frame_start_d;
    logic             overflow_q, overflow_d;

    logic [LVL_W-1:0] fifo_level;
    logic [WIDTH-1:0] fifo_head;
    logic             ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic             begin_frame;
    logic             data_bit;
    logic [WIDTH-1:0] shift_next;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_16  (clk_16),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.sample_in),
        .rd_data (fifo_head),
        .level   (fifo_level)
    );

    assign ready  = (fifo_level < LVL_W'(DEPTH));
    assign accept = bus.sample_valid && ready;
    assign push   = accept && !(SKIP_ZERO && (bus.sample_in == '0));

    assign data_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_q[WIDTH-1:1]};

    // Overflow is sticky once a sample arrives while the FIFO is full
    always_comb begin
        overflow_d = overflow_q | (bus.sample_valid & ~ready);
    end

    // Frame sequencing: next state, counter, shifter and the registered outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        ctrl_bit_d    = 1'b0;
        ctrl_en_d     = 1'b0;
        frame_start_d = 1'b0;
        pop           = 1'b0;
        begin_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_level != '0) begin
                    begin_frame = 1'b1;
                end
            end
            SYNC: begin
                ctrl_en_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    ctrl_bit_d = sync_bit(SYNC_WORD, int'(cnt_q) - 1);
                end else begin
                    state_d    = DATA;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    ctrl_bit_d = data_bit;
                    shift_d    = shift_next;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    ctrl_en_d  = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                    ctrl_bit_d = data_bit;
                    shift_d    = shift_next;
                end else if (fifo_level != '0) begin
                    begin_frame = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_frame) begin
            pop           = 1'b1;
            shift_d       = fifo_head;
            cnt_d         = CNT_W'(SYNC_LEN - 1);
            state_d       = SYNC;
            ctrl_bit_d    = sync_bit(SYNC_WORD, SYNC_LEN - 1);
            ctrl_en_d     = 1'b1;
            frame_start_d = 1'b1;
        end
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            ctrl_bit_q    <= 1'b0;
            ctrl_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            ctrl_bit_q    <= ctrl_bit_d;
            ctrl_en_q     <= ctrl_en_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.sample_ready = ready;
    assign bus.ctrl_bit     = ctrl_bit_q;
    assign bus.ctrl_en      = ctrl_en_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.overflow     = overflow_q;
    assign bus.fifo_level   = fifo_level;

endmodule

// File: tb/tb_fsk_frame_serializer.sv
// Directed bench for fsk_frame_serializer: three instances cover the default
// configuration, MSB-first data order and zero samples framed (SKIP_ZERO=0).
module tb_fsk_frame_serializer;

    logic clk_16 = 1'b0;
    logic reset  = 1'b1;

    int compare_count = 0;
    int fail_count    = 0;

    always #5 clk_16 = ~clk_16;

    fsk_frame_serializer_if #(.WIDTH(16), .DEPTH(4)) bus0 ();
    fsk_frame_serializer_if #(.WIDTH(16), .DEPTH(4)) bus1 ();
    fsk_frame_serializer_if #(.WIDTH(16), .DEPTH(4)) bus2 ();

    fsk_frame_serializer #(
        .WIDTH(16), .DEPTH(4), .SYNC_LEN(8), .SYNC_WORD(16'h00A5),
        .MSB_FIRST(1'b0), .SKIP_ZERO(1'b1)
    ) dut0 (.clk_16(clk_16), .reset(reset), .bus(bus0.slave));

    fsk_frame_serializer #(
        .WIDTH(16), .DEPTH(4), .SYNC_LEN(8), .SYNC_WORD(16'h00A5),
        .MSB_FIRST(1'b1), .SKIP_ZERO(1'b1)
    ) dut1 (.clk_16(clk_16), .reset(reset), .bus(bus1.slave));

    fsk_frame_serializer #(
        .WIDTH(16), .DEPTH(4), .SYNC_LEN(8), .SYNC_WORD(16'h00A5),
        .MSB_FIRST(1'b0), .SKIP_ZERO(1'b0)
    ) dut2 (.clk_16(clk_16), .reset(reset), .bus(bus2.slave));

    logic [2:0] en_w, bit_w, fs_w;
    assign en_w  = {bus2.ctrl_en, bus1.ctrl_en, bus0.ctrl_en};
    assign bit_w = {bus2.ctrl_bit, bus1.ctrl_bit, bus0.ctrl_bit};
    assign fs_w  = {bus2.frame_start, bus1.frame_start, bus0.frame_start};

    task automatic tick();
        @(posedge clk_16);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int which, input logic [15:0] value,
                                  input logic valid);
        case (which)
            0: begin bus0.sample_in = value; bus0.sample_valid = valid; end
            1: begin bus1.sample_in = value; bus1.sample_valid = valid; end
            default: begin bus2.sample_in = value; bus2.sample_valid = valid; end
        endcase
    endtask

    // Called right after the push edge; stream[23] is the first bit on the wire
    task automatic watch_frame(input int which, input string tag,
                               input logic [23:0] stream);
        tick();
        for (int i = 0; i < 24; i++) begin
            check_output({tag, "_en"}, 32'(en_w[which]), 32'd1);
            check_output({tag, "_bit"}, 32'(bit_w[which]), 32'(stream[23-i]));
            check_output({tag, "_fs"}, 32'(fs_w[which]), 32'(i == 0));
            tick();
        end
        check_output({tag, "_en_end"}, 32'(en_w[which]), 32'd0);
        check_output({tag, "_bit_end"}, 32'(bit_w[which]), 32'd0);
    endtask

    initial begin
        logic [7:0]  sync_word;
        logic [15:0] samp;
        logic        exp_bit;
        int          found;
        int          f, pos;

        sync_word = 8'hA5;
        apply_stimulus(0, 16'h0000, 1'b0);
        apply_stimulus(1, 16'h0000, 1'b0);
        apply_stimulus(2, 16'h0000, 1'b0);

        // Reset values
        #1 reset = 1'b0;
        #20;
        check_output("rst_bit", 32'(bus0.ctrl_bit), 32'd0);
        check_output("rst_en", 32'(bus0.ctrl_en), 32'd0);
        check_output("rst_fs", 32'(bus0.frame_start), 32'd0);
        check_output("rst_ovf", 32'(bus0.overflow), 32'd0);
        check_output("rst_level", 32'(bus0.fifo_level), 32'd0);
        check_output("rst_ready", 32'(bus0.sample_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        tick();

        // One LSB-first frame of 16'h8001
        apply_stimulus(0, 16'h8001, 1'b1);
        tick();
        apply_stimulus(0, 16'h0000, 1'b0);
        check_output("lsb_level1", 32'(bus0.fifo_level), 32'd1);
        check_output("lsb_idle_en", 32'(bus0.ctrl_en), 32'd0);
        watch_frame(0, "lsb", 24'b10100101_1000000000000001);
        check_output("lsb_level0", 32'(bus0.fifo_level), 32'd0);

        // MSB-first frame of 16'h0003
        apply_stimulus(1, 16'h0003, 1'b1);
        tick();
        apply_stimulus(1, 16'h0000, 1'b0);
        watch_frame(1, "msb", 24'b10100101_0000000000000011);

        // Zero sample suppressed
        apply_stimulus(0, 16'h0000, 1'b1);
        tick();
        apply_stimulus(0, 16'h0000, 1'b0);
        check_output("skip_ready", 32'(bus0.sample_ready), 32'd1);
        check_output("skip_level", 32'(bus0.fifo_level), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check_output("skip_en", 32'(bus0.ctrl_en), 32'd0);
        end

        // Zero sample framed when suppression is off
        apply_stimulus(2, 16'h0000, 1'b1);
        tick();
        apply_stimulus(2, 16'h0000, 1'b0);
        check_output("zero_level", 32'(bus2.fifo_level), 32'd1);
        watch_frame(2, "zero", 24'b10100101_0000000000000000);

        // Five samples on consecutive cycles give five gap-free frames
        for (int t = 0; t < 122; t++) begin
            if (t < 5) apply_stimulus(0, 16'(t + 1), 1'b1);
            else       apply_stimulus(0, 16'h0000, 1'b0);
            tick();
            if (t >= 1 && t <= 120) begin
                f    = (t - 1) / 24;
                pos  = (t - 1) % 24;
                samp = 16'(f + 1);
                if (pos < 8) exp_bit = sync_word[7-pos];
                else         exp_bit = samp[pos-8];
                check_output("b2b_en", 32'(bus0.ctrl_en), 32'd1);
                check_output("b2b_fs", 32'(bus0.frame_start), 32'(pos == 0));
                check_output("b2b_bit", 32'(bus0.ctrl_bit), 32'(exp_bit));
            end else begin
                check_output("b2b_en_off", 32'(bus0.ctrl_en), 32'd0);
            end
        end
        check_output("b2b_ovf", 32'(bus0.overflow), 32'd0);

        // Fill the FIFO while a frame is in its data phase
        apply_stimulus(0, 16'h1234, 1'b1);
        tick();
        apply_stimulus(0, 16'h0000, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(0, 16'(k + 1), 1'b1);
            tick();
            if (k == 3) begin
                check_output("full_level", 32'(bus0.fifo_level), 32'd4);
                check_output("full_ready", 32'(bus0.sample_ready), 32'd0);
                check_output("full_ovf0", 32'(bus0.overflow), 32'd0);
            end
            if (k == 4) check_output("full_ovf1", 32'(bus0.overflow), 32'd1);
        end
        apply_stimulus(0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_output("ovf_sticky", 32'(bus0.overflow), 32'd1);

        // Reset at bit 10 of a queued frame
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            tick();
            if (bus0.frame_start) found = 1;
        end
        check_output("fs_seen", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check_output("pre_rst_en", 32'(bus0.ctrl_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_bit", 32'(bus0.ctrl_bit), 32'd0);
        check_output("mid_rst_en", 32'(bus0.ctrl_en), 32'd0);
        check_output("mid_rst_fs", 32'(bus0.frame_start), 32'd0);
        check_output("mid_rst_ovf", 32'(bus0.overflow), 32'd0);
        check_output("mid_rst_level", 32'(bus0.fifo_level), 32'd0);
        check_output("mid_rst_ready", 32'(bus0.sample_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_output("post_rst_en", 32'(bus0.ctrl_en), 32'd0);
        check_output("post_rst_level", 32'(bus0.fifo_level), 32'd0);
        apply_stimulus(0, 16'h8001, 1'b1);
        tick();
        apply_stimulus(0, 16'h0000, 1'b0);
        watch_frame(0, "after_rst", 24'b10100101_1000000000000001);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fsk_frame_serializer.md
# fsk_frame_serializer

Parametrised framed parallel-to-serial stage for the FSK transmitter. It buffers ADC samples in a small FIFO, prefixes each sample with a sync word, and shifts the frame out one bit per `clk_16` cycle as the modulator control bit with a qualifying enable. It sits between the ADC sample register and the FSK modulator, replacing the fixed 16-bit, unframed serializer. Unlike that serializer, it adds:
- framing and back-pressure;
- optional zero-sample suppression;
- a selectable data bit order.

## Interface
- `WIDTH`, 16, sample width in bits (4..32)
- `DEPTH`, 4, sample FIFO depth in entries (power of 2, ≥2)
- `SYNC_LEN`, 8, sync word length in bits (1..16)
- `SYNC_WORD`, 8'hA5, sync pattern; always sent MSB first
- `MSB_FIRST`, 0, data order: 0 = bit 0 first, 1 = bit WIDTH-1 first
- `SKIP_ZERO`, 1, 1 = accepted all-zero samples are discarded, not framed

Ports:
- `clk_16`  in  1  bit clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low
- `sample_in`  in  WIDTH  sample from ADC capture register, synchronous to `clk_16`
- `sample_valid`  in  1  sample_in valid this cycle
- `sample_ready`  out  1  FIFO can accept; transfer on valid && ready
- `ctrl_bit`  out  1  serial bit to modulator; registered
- `ctrl_en`  out  1  high while ctrl_bit carries sync or data; registered
- `frame_start`  out  1  one-cycle pulse coincident with the first sync bit
- `overflow`  out  1  sticky: valid asserted while not ready; cleared only by reset
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset (async assert, sync release): FIFO empty, FSM IDLE, bit counter 0. Outputs:
  - ctrl_bit=0, ctrl_en=0, frame_start=0, overflow=0;
  - fifo_level=0, sample_ready=1.
- Write side:
  - sample_ready = (fifo_level < DEPTH), combinational from level.
  - Accept = sample_valid && sample_ready.
  - With SKIP_ZERO=1, an accepted sample equal to 0 is consumed but not written.
  - sample_valid && !sample_ready sets overflow; the sample is dropped.
- FSM states: IDLE, SYNC, DATA.
  - IDLE: if FIFO non-empty → pop head into shift register, load bit counter = SYNC_LEN-1, go SYNC.
  - SYNC: emit SYNC_WORD[cnt], cnt decrements. At cnt=0 → load cnt=WIDTH-1, go DATA.
  - DATA: emit the data bit selected by MSB_FIRST; cnt decrements. At cnt=0:
    - FIFO non-empty → pop, reload SYNC_LEN-1, go SYNC (no gap);
    - else → go IDLE.
- IDLE output: ctrl_bit=0, ctrl_en=0.
- Simultaneous push and pop in the same cycle is legal; the level is unchanged.
- Full with a pop in the same cycle: sample_ready is still 0 that cycle. There is no pass-through.
- Reset mid-frame: the frame is abandoned and FIFO contents are lost. No partial frame resumes.

## Timing
- Sample accepted at edge N with the FIFO empty and the FSM in IDLE:
  - fifo_level=1 after edge N;
  - pop at edge N+1;
  - first sync bit on ctrl_bit with ctrl_en=1 and frame_start=1 after edge N+1.
- Frame occupies exactly SYNC_LEN+WIDTH consecutive cycles with ctrl_en=1. Each bit is held one cycle.
- Back-to-back frames: ctrl_en stays high continuously. frame_start pulses every SYNC_LEN+WIDTH cycles.
- After the last data bit: ctrl_en=0 on the next cycle if the FIFO is empty.
- Level/ready reflect a pop one edge after the pop.

## Structure
- Package `fsk_tx_pkg`:
  - FSM state enum (IDLE/SYNC/DATA);
  - default SYNC_WORD/SYNC_LEN constants shared with the receiver's sync detector.
- Sub-module `sample_fifo` (WIDTH, DEPTH):
  - synchronous FIFO with push/pop and level;
  - pointers wrap modulo DEPTH;
  - level sized to represent DEPTH.
- Top holds the FSM, bit counter, shift register and output registers.

## Test plan
- Defaults, push 16'h8001 once:
  - frame_start one cycle;
  - ctrl_bit = 1,0,1,0,0,1,0,1 then 1, fourteen 0s, 1;
  - 24 cycles of ctrl_en=1, then IDLE with ctrl_bit=0.
- MSB_FIRST=1, push 16'h0003 → data bits are fourteen 0s then 1,1.
- SKIP_ZERO=1, push 16'h0000 → sample_ready stays 1, ctrl_en never asserts, fifo_level stays 0. With SKIP_ZERO=0 → one frame of sync plus 16 zero bits.
- Push 5 samples (DEPTH=4) on consecutive cycles:
  - the first pops at edge N+1, so all 5 are accepted and overflow stays 0;
  - 5 back-to-back frames, frame_start at 24-cycle spacing, ctrl_en never drops.
- Hold sample_valid with 6+ samples while the FSM is in DATA → fifo_level reaches 4, sample_ready=0, overflow=1 and stays set.
- Assert reset at bit 10 of a frame → all outputs at reset values immediately. After release, a new push yields a clean full frame starting with the sync word.
